// File: rtl/mc_pkg.sv
// Shared definitions for the memory-array frame arbiter: frame field
// layout, arbiter state encoding and the round-robin winner search.
package mc_pkg;

  localparam int MC_ADDR_W = 20;
  localparam int MC_DATA_W = 64;
  localparam int FRAME_W   = MC_ADDR_W + MC_DATA_W + 3;

  // Frame layout is {sof, eof, rw_flag, addr, data}; rw_flag=1 means write.
  localparam int DATA_LSB  = 0;
  localparam int ADDR_LSB  = MC_DATA_W;
  localparam int RW_BIT    = MC_ADDR_W + MC_DATA_W;
  localparam int EOF_BIT   = RW_BIT + 1;
  localparam int SOF_BIT   = RW_BIT + 2;

  localparam int MAX_PORTS = 8;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arbState_t;

  // First requester at or after ptr, wrapping modulo numPorts.
  // Returns 0 when nothing requests; the caller only uses it when some port does.
  function automatic logic [2:0] rrWinner(input logic [MAX_PORTS-1:0] req,
                                          input logic [2:0]           ptr,
                                          input int                   numPorts);
    logic [2:0] win;
    logic       found;
    int         idx;
    win   = '0;
    found = 1'b0;
    for (int k = 0; k < MAX_PORTS; k++) begin
      idx = int'(ptr) + k;
      if (idx >= numPorts) idx = idx - numPorts;
      if (k < numPorts && !found && req[idx]) begin
        win   = 3'(idx);
        found = 1'b1;
      end
    end
    return win;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with the head word presented combinationally.
// A push is accepted while full when a pop happens in the same cycle.
module sync_fifo #(
  parameter int DATA_WIDTH = 2,
  parameter int FIFO_DEPTH = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_wrEn,
  input  logic [DATA_WIDTH-1:0] i_wrData,
  input  logic                  i_rdEn,
  output logic [DATA_WIDTH-1:0] o_rdData,
  output logic                  o_full,
  output logic                  o_empty
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]      r_wrPtr;
  logic [PTR_W-1:0]      r_rdPtr;
  logic [CNT_W-1:0]      r_count;
  logic                  w_doPush;
  logic                  w_doPop;

  assign o_full   = (r_count == CNT_W'(FIFO_DEPTH));
  assign o_empty  = (r_count == '0);
  assign o_rdData = r_mem[r_rdPtr];
  assign w_doPop  = i_rdEn && !o_empty;
  assign w_doPush = i_wrEn && (!o_full || w_doPop);

  // Storage array; contents need no reset because occupancy guards every read.
  always_ff @(posedge clk) begin
    if (w_doPush) r_mem[r_wrPtr] <= i_wrData;
  end

  // Pointer and occupancy tracking; a simultaneous push and pop leaves the count unchanged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_doPush) r_wrPtr <= (r_wrPtr == PTR_W'(FIFO_DEPTH - 1)) ? '0 : r_wrPtr + 1'b1;
      if (w_doPop)  r_rdPtr <= (r_rdPtr == PTR_W'(FIFO_DEPTH - 1)) ? '0 : r_rdPtr + 1'b1;
      case ({w_doPush, w_doPop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/mc_frame_arbiter.sv
// Frame arbiter: grants whole frames (sof..eof) from NUM_PORTS streams
// round-robin onto one array port and routes read data back to the
// port that issued each read beat.
// Optional macro MC_ARB_QOS_EN adds the in_qos input; the winner is then the
// highest-qos requester, ties broken round-robin.
module mc_frame_arbiter
  import mc_pkg::*;
#(
  parameter int NUM_PORTS = 3,
  parameter int ADDR_W    = MC_ADDR_W,
  parameter int DATA_W    = MC_DATA_W,
  parameter int RID_DEPTH = 64,
  localparam int FW       = ADDR_W + DATA_W + 3,
  localparam int ID_W     = $clog2(NUM_PORTS)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_PORTS*FW-1:0] in_frame_data,
  input  logic [NUM_PORTS-1:0]    in_frame_valid,
  output logic [NUM_PORTS-1:0]    in_frame_ready,
`ifdef MC_ARB_QOS_EN
  input  logic [NUM_PORTS*2-1:0]  in_qos,
`endif
  output logic [FW-1:0]           out_frame_data,
  output logic                    out_frame_valid,
  input  logic                    out_frame_ready,
  input  logic [DATA_W-1:0]       array_rdata,
  input  logic                    array_rvalid,
  output logic [DATA_W-1:0]       port_rdata,
  output logic [NUM_PORTS-1:0]    port_rvalid,
  output logic [ID_W-1:0]         grant_id,
  output logic                    busy,
  output logic                    rid_underflow
);

  // Field positions are anchored to the frame MSB so they hold for any address/data width.
  localparam int L_RW_BIT  = FW - (FRAME_W - RW_BIT);
  localparam int L_EOF_BIT = FW - (FRAME_W - EOF_BIT);

  arbState_t            r_state;
  logic                 r_busy;
  logic [ID_W-1:0]      r_grant;
  logic [ID_W-1:0]      r_rrPtr;
  logic                 r_underflow;

  logic [NUM_PORTS-1:0] w_arbReq;
  logic [ID_W-1:0]      w_winner;
  logic [FW-1:0]        w_sel;
  logic                 w_selValid;
  logic                 w_stall;
  logic                 w_handshake;
  logic                 w_ridPush;
  logic                 w_ridFull;
  logic                 w_fifoFull;
  logic                 w_fifoEmpty;
  logic [ID_W-1:0]      w_ridHead;

`ifdef MC_ARB_QOS_EN
  logic [1:0]           w_qosMax;

  // Narrow the request set to the ports sharing the highest qos among requesters.
  always_comb begin
    w_qosMax = '0;
    w_arbReq = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (in_frame_valid[p] && (in_qos[2*p +: 2] > w_qosMax)) w_qosMax = in_qos[2*p +: 2];
    end
    for (int p = 0; p < NUM_PORTS; p++) begin
      w_arbReq[p] = in_frame_valid[p] && (in_qos[2*p +: 2] == w_qosMax);
    end
  end
`else
  assign w_arbReq = in_frame_valid;
`endif

  assign w_winner = ID_W'(rrWinner(MAX_PORTS'(w_arbReq), 3'(r_rrPtr), NUM_PORTS));

  // Select the granted port's frame and valid.
  always_comb begin
    w_sel      = '0;
    w_selValid = 1'b0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (r_grant == ID_W'(p)) begin
        w_sel      = in_frame_data[p*FW +: FW];
        w_selValid = in_frame_valid[p];
      end
    end
  end

  // A pop in this cycle frees a slot, so a full FIFO only blocks reads when nothing returns.
  assign w_ridFull   = w_fifoFull && !array_rvalid;
  assign w_stall     = !w_sel[L_RW_BIT] && w_ridFull;
  assign w_handshake = (r_state == BUSY) && w_selValid && !w_stall && out_frame_ready;
  assign w_ridPush   = w_handshake && !w_sel[L_RW_BIT];

  assign out_frame_data  = (r_state == BUSY) ? w_sel : '0;
  assign out_frame_valid = (r_state == BUSY) && w_selValid && !w_stall;

  // Only the granted port sees ready, and only while its beat could be taken.
  always_comb begin
    in_frame_ready = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      in_frame_ready[p] = (r_state == BUSY) && (r_grant == ID_W'(p)) && out_frame_ready && !w_stall;
    end
  end

  // Grant FSM: register the winner in IDLE, hold it until the eof beat handshakes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_busy  <= 1'b0;
      r_grant <= '0;
      r_rrPtr <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (|in_frame_valid) begin
            r_state <= BUSY;
            r_busy  <= 1'b1;
            r_grant <= w_winner;
            r_rrPtr <= (w_winner == ID_W'(NUM_PORTS - 1)) ? '0 : w_winner + 1'b1;
          end
        end
        BUSY: begin
          if (w_handshake && w_sel[L_EOF_BIT]) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  // Remember which port each read beat came from, in issue order.
  sync_fifo #(
    .DATA_WIDTH (ID_W),
    .FIFO_DEPTH (RID_DEPTH)
  ) u_rid_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_wrEn   (w_ridPush),
    .i_wrData (r_grant),
    .i_rdEn   (array_rvalid),
    .o_rdData (w_ridHead),
    .o_full   (w_fifoFull),
    .o_empty  (w_fifoEmpty)
  );

  // Flag read data that arrives with no outstanding read beat; stays set until reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_underflow <= 1'b0;
    else if (array_rvalid && w_fifoEmpty) r_underflow <= 1'b1;
  end

  // Route returning read data to the port at the head of the ID FIFO.
  always_comb begin
    port_rvalid = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      port_rvalid[p] = array_rvalid && !w_fifoEmpty && (w_ridHead == ID_W'(p));
    end
  end

  assign port_rdata    = array_rdata;
  assign grant_id      = r_grant;
  assign busy          = r_busy;
  assign rid_underflow = r_underflow;

endmodule

// File: tb/tb_mc_frame_arbiter.sv
// Randomized bench for mc_frame_arbiter with a transaction-level reference:
// per-port frame queues as sources, a queue of outstanding read owners, and
// a priority search for the next frame owner.
`timescale 1ns/1ps
module tb_mc_frame_arbiter;
  import mc_pkg::*;

  localparam int NP  = 3;
  localparam int AW  = MC_ADDR_W;
  localparam int DW  = MC_DATA_W;
  localparam int FW  = AW + DW + 3;
  localparam int RD  = 64;
  localparam int IDW = $clog2(NP);

  typedef logic [FW-1:0] beat_t;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic [NP*FW-1:0]     inData;
  logic [NP-1:0]        inValid;
  logic [NP-1:0]        inReady;
  logic [NP*2-1:0]      inQos;
  logic [FW-1:0]        outData;
  logic                 outValid;
  logic                 outReady;
  logic [DW-1:0]        arrayRdata;
  logic                 arrayRvalid;
  logic [DW-1:0]        portRdata;
  logic [NP-1:0]        portRvalid;
  logic [IDW-1:0]       grantId;
  logic                 busyO;
  logic                 ridUnder;

  always #5 clk = ~clk;

  mc_frame_arbiter #(
    .NUM_PORTS (NP),
    .ADDR_W    (AW),
    .DATA_W    (DW),
    .RID_DEPTH (RD)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .in_frame_data   (inData),
    .in_frame_valid  (inValid),
    .in_frame_ready  (inReady),
`ifdef MC_ARB_QOS_EN
    .in_qos          (inQos),
`endif
    .out_frame_data  (outData),
    .out_frame_valid (outValid),
    .out_frame_ready (outReady),
    .array_rdata     (arrayRdata),
    .array_rvalid    (arrayRvalid),
    .port_rdata      (portRdata),
    .port_rvalid     (portRvalid),
    .grant_id        (grantId),
    .busy            (busyO),
    .rid_underflow   (ridUnder)
  );

  // Reference state
  beat_t srcQ0[$];
  beat_t srcQ1[$];
  beat_t srcQ2[$];
  int    ridQ[$];
  int    mOwner;
  int    mLastGrant;
  int    mPtr;
  bit    mUnder;

  int nCompared   = 0;
  int nMismatched = 0;

  // Traffic knobs (percentages)
  int pNewFrame, pRead, pRvalid, pReady, pBubble;
  bit allowUnderflow;

  task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    nCompared++;
    if (obs !== exp) begin
      nMismatched++;
      $display("[TB] FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic int srcSize(input int p);
    case (p)
      0: return srcQ0.size();
      1: return srcQ1.size();
      default: return srcQ2.size();
    endcase
  endfunction

  function automatic beat_t srcFront(input int p);
    case (p)
      0: return srcQ0[0];
      1: return srcQ1[0];
      default: return srcQ2[0];
    endcase
  endfunction

  task automatic srcPush(input int p, input beat_t b);
    case (p)
      0: srcQ0.push_back(b);
      1: srcQ1.push_back(b);
      default: srcQ2.push_back(b);
    endcase
  endtask

  task automatic srcPop(input int p);
    case (p)
      0: void'(srcQ0.pop_front());
      1: void'(srcQ1.pop_front());
      default: void'(srcQ2.pop_front());
    endcase
  endtask

  task automatic modelReset();
    mOwner     = -1;
    mLastGrant = 0;
    mPtr       = 0;
    mUnder     = 1'b0;
    ridQ.delete();
    srcQ0.delete();
    srcQ1.delete();
    srcQ2.delete();
  endtask

  task automatic genFrames();
    for (int p = 0; p < NP; p++) begin
      if (srcSize(p) == 0 && $urandom_range(99) < pNewFrame) begin
        int           len;
        bit           rw;
        logic [AW-1:0] addr;
        len  = $urandom_range(1, 4);
        rw   = ($urandom_range(99) >= pRead);
        addr = AW'($urandom);
        for (int b = 0; b < len; b++) begin
          beat_t bt;
          bt = '0;
          bt[SOF_BIT] = (b == 0);
          bt[EOF_BIT] = (b == len - 1);
          bt[RW_BIT]  = rw;
          bt[ADDR_LSB +: AW] = addr + AW'(b);
          bt[DATA_LSB +: DW] = {$urandom, $urandom};
          srcPush(p, bt);
        end
      end
    end
  endtask

  task automatic applyStimulus();
    genFrames();
    for (int p = 0; p < NP; p++) begin
      if (srcSize(p) > 0 && $urandom_range(99) >= pBubble) begin
        inValid[p] = 1'b1;
        inData[p*FW +: FW] = srcFront(p);
      end else begin
        inValid[p] = 1'b0;
        inData[p*FW +: FW] = '0;
      end
    end
`ifdef MC_ARB_QOS_EN
    inQos = NP*2'($urandom);
`else
    inQos = '0;
`endif
    outReady    = ($urandom_range(99) < pReady);
    arrayRvalid = ($urandom_range(99) < pRvalid) && (allowUnderflow || ridQ.size() > 0);
    arrayRdata  = {$urandom, $urandom};
  endtask

  // Compare DUT against the reference for the current cycle, then advance the reference.
  task automatic modelStep();
    bit             busyE, stallE, oValidE, fullE, hs;
    logic [NP-1:0]  readyE, prvE;
    beat_t          bt;
    int             g, best;

    busyE = (mOwner >= 0);
    g     = busyE ? mOwner : 0;
    bt    = inData[g*FW +: FW];
    fullE = (ridQ.size() >= RD) && !arrayRvalid;
    stallE  = busyE && !bt[RW_BIT] && fullE;
    oValidE = busyE && inValid[g] && !stallE;
    readyE  = '0;
    if (busyE) readyE[g] = outReady && !stallE;
    prvE = '0;
    if (arrayRvalid && ridQ.size() > 0) prvE[ridQ[0]] = 1'b1;

    checkOutput("busy",          busyO,      busyE);
    checkOutput("grant_id",      grantId,    mLastGrant);
    checkOutput("rid_underflow", ridUnder,   mUnder);
    checkOutput("out_valid",     outValid,   oValidE);
    checkOutput("in_ready",      inReady,    readyE);
    checkOutput("port_rvalid",   portRvalid, prvE);
    if (oValidE)     checkOutput("out_data",   outData,   bt);
    if (arrayRvalid) checkOutput("port_rdata", portRdata, arrayRdata);

    hs = oValidE && outReady;
    if (arrayRvalid) begin
      if (ridQ.size() > 0) void'(ridQ.pop_front());
      else mUnder = 1'b1;
    end
    if (hs) begin
      if (!bt[RW_BIT]) ridQ.push_back(g);
      srcPop(g);
      if (bt[EOF_BIT]) mOwner = -1;
    end else if (!busyE && (|inValid)) begin
      best = -1;
      for (int k = 0; k < NP; k++) begin
        int idx;
        idx = (mPtr + k) % NP;
        if (inValid[idx] && (best < 0 || inQos[2*idx +: 2] > inQos[2*best +: 2])) best = idx;
      end
      mOwner     = best;
      mLastGrant = best;
      mPtr       = (best + 1) % NP;
    end
  endtask

  task automatic runCycles(input int n);
    repeat (n) begin
      applyStimulus();
      #4;
      modelStep();
      @(posedge clk);
      #1;
    end
  endtask

  task automatic zeroInputs();
    inData      = '0;
    inValid     = '0;
    inQos       = '0;
    outReady    = 1'b0;
    arrayRvalid = 1'b0;
    arrayRdata  = '0;
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_busy"},      busyO,      1'b0);
    checkOutput({tag, "_grant"},     grantId,    '0);
    checkOutput({tag, "_in_ready"},  inReady,    '0);
    checkOutput({tag, "_out_valid"}, outValid,   1'b0);
    checkOutput({tag, "_rvalid"},    portRvalid, '0);
    checkOutput({tag, "_underflow"}, ridUnder,   1'b0);
  endtask

  initial begin
    int guard;
    rst_n = 1'b0;
    zeroInputs();
    modelReset();
    allowUnderflow = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkResetState("reset");
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Mixed read/write traffic with back-pressure and bubbles
    pNewFrame = 30; pRead = 50; pRvalid = 40; pReady = 80; pBubble = 10;
    runCycles(1500);

    // Continuous requests from every port
    pNewFrame = 100; pBubble = 0; pReady = 100; pRvalid = 50;
    runCycles(400);

    // Fill the read-ID FIFO with no returns, then trickle returns while reads keep coming
    pRead = 100; pRvalid = 0;
    runCycles(200);
    pRvalid = 20;
    runCycles(400);
    pRvalid = 100; pNewFrame = 0;
    runCycles(100);

    // Reset in the middle of a multi-beat frame
    pNewFrame = 100; pRead = 50; pRvalid = 30; pReady = 100; pBubble = 0;
    guard = 0;
    while (!(mOwner >= 0 && srcSize(mOwner) >= 2 && srcFront(mOwner)[SOF_BIT] == 1'b0) && guard < 2000) begin
      runCycles(1);
      guard++;
    end
    checkOutput("midframe_reached", (guard < 2000), 1'b1);
    zeroInputs();
    rst_n = 1'b0;
    #4;
    checkResetState("midreset");
    modelReset();
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Read data with nothing outstanding
    pNewFrame = 0; pRvalid = 100; allowUnderflow = 1'b1;
    runCycles(3);
    allowUnderflow = 1'b0;

    // More traffic after reset; underflow flag must stay set
    pNewFrame = 40; pRead = 60; pRvalid = 40; pReady = 70; pBubble = 15;
    runCycles(600);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
